data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 138 +++++++++++++
 tb/tb_data_cache.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a word-serial refill FSM.
// Define DATA_CACHE_STATS_EN to add the hit_count/miss_count outputs.
module data_cache #(
    parameter int unsigned LINES = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic [31:0] mem_address,
    output logic [31:0] mem_value,
    output logic        mem_write,
    input  logic [31:0] mem_data
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned OW = $clog2(WORDS);
    localparam int unsigned TW = 32 - 2 - IW - OW;

    typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   cnt_q, cnt_d;
    logic [LINES-1:0] valid_q;
    logic [TW-1:0]   tag_q  [LINES];
    logic [31:0]     data_q [LINES][WORDS];

    logic [OW-1:0] offset;
    logic [IW-1:0] index;
    logic [TW-1:0] tag;
    logic          hit;
    logic          refill_we;
    logic          fill_done;
    logic          write_hit;
    logic          read_hit;
    logic          read_miss;

    assign offset = cpu_addr[2 +: OW];
    assign index  = cpu_addr[2 + OW +: IW];
    assign tag    = cpu_addr[31 -: TW];
    assign hit    = valid_q[index] && (tag_q[index] == tag);

    // Read data is always the addressed word; only meaningful on a hit in IDLE.
    assign cpu_rdata = data_q[index][offset];
    assign mem_value = cpu_wdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        mem_write   = 1'b0;
        mem_address = cpu_addr;
        refill_we   = 1'b0;
        fill_done   = 1'b0;
        write_hit   = 1'b0;
        read_hit    = 1'b0;
        read_miss   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_write) begin
                    stall   = 1'b1;
                    state_d = StWrite;
                end else if (cpu_read) begin
                    if (hit) begin
                        read_hit = 1'b1;
                    end else begin
                        read_miss = 1'b1;
                        stall     = 1'b1;
                        cnt_d     = '0;
                        state_d   = StRefill;
                    end
                end
            end
            StRefill: begin
                stall       = 1'b1;
                mem_address = {tag, index, cnt_q, 2'b00};
                refill_we   = 1'b1;
                cnt_d       = cnt_q + OW'(1);
                if (cnt_q == OW'(WORDS - 1)) begin
                    fill_done = 1'b1;
                    state_d   = StIdle;
                end
            end
            StWrite: begin
                mem_address = {cpu_addr[31:2], 2'b00};
                mem_write   = 1'b1;
                write_hit   = hit;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (fill_done) valid_q[index] <= 1'b1;
        end
    end

    // Tags and data need no reset: valid bits gate every use.
    always_ff @(posedge clock) begin
        if (fill_done) tag_q[index] <= tag;
        if (refill_we) begin
            data_q[index][cnt_q] <= mem_data;
        end else if (write_hit) begin
            data_q[index][offset] <= cpu_wdata;
        end
    end

`ifdef DATA_CACHE_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (read_hit)  hit_count  <= hit_count + 32'd1;
            if (read_miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: stimulus queues expected read data and RAM stores,
// a negedge monitor pops and compares whenever a read completes or mem_write is seen.
module tb_data_cache;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic [31:0] mem_address;
    logic [31:0] mem_value;
    logic        mem_write;
    logic [31:0] mem_data;
`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [256];
    logic [31:0] rq [$];
    logic [63:0] wq [$];

    always #5 clock = ~clock;

    data_cache #(.LINES(8), .WORDS(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_rdata   (cpu_rdata),
        .stall       (stall),
        .mem_address (mem_address),
        .mem_value   (mem_value),
        .mem_write   (mem_write),
        .mem_data    (mem_data)
`ifdef DATA_CACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    assign mem_data = ram[mem_address[9:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // RAM model: stores sampled mid-cycle, committed at the rising edge.
    initial begin
        logic        w;
        logic [31:0] a, v;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h10] = 32'h11111111; ram[8'h11] = 32'h22222222;
        ram[8'h12] = 32'h33333333; ram[8'h13] = 32'h44444444;
        ram[8'h30] = 32'h55555555; ram[8'h31] = 32'h66666666;
        ram[8'h32] = 32'h77777777; ram[8'h33] = 32'h88888888;
        forever begin
            @(negedge clock);
            w = mem_write; a = mem_address; v = mem_value;
            @(posedge clock);
            if (w) ram[a[9:2]] = v;
        end
    end

    // Monitor: completed reads and RAM stores against the scoreboard queues.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clock);
            if (reset_n && cpu_read && !cpu_write && !stall) begin
                if (rq.size() == 0) check("unexpected_read", cpu_rdata, 32'hxxxxxxxx);
                else check("read_data", cpu_rdata, rq.pop_front());
            end
            if (mem_write) begin
                if (wq.size() == 0) check("unexpected_mem_write", {31'h0, mem_write}, 32'h0);
                else begin
                    e = wq.pop_front();
                    check("write_addr", mem_address, e[63:32]);
                    check("write_value", mem_value, e[31:0]);
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp,
                           input int exp_stalls);
        int n;
        logic [31:0] addrs [8];
        logic [31:0] base;
        @(posedge clock); #1;
        cpu_addr = addr;
        cpu_read = 1'b1;
        rq.push_back(exp);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (!stall) break;
            if (n < 8) addrs[n] = mem_address;
            n++;
        end
        check("read_stall_cycles", n, exp_stalls);
        if (n == 5 && exp_stalls == 5) begin
            base = {addr[31:4], 4'h0};
            for (int i = 0; i < 4; i++) check("refill_addr", addrs[i+1], base + 32'(4 * i));
        end
        @(posedge clock); #1;
        cpu_read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        int n;
        @(posedge clock); #1;
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_write = 1'b1;
        wq.push_back({addr, data});
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (!stall) break;
            n++;
        end
        check("write_stall_cycles", n, 1);
        check("write_cycle_mem_write", {31'h0, mem_write}, 32'h1);
        @(posedge clock); #1;
        cpu_write = 1'b0;
    endtask

    initial begin
        cpu_addr = 32'h124;
        #12;
        check("reset_stall", {31'h0, stall}, 32'h0);
        check("reset_mem_write", {31'h0, mem_write}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_mem_address", mem_address, 32'h124);
        check("idle_stall", {31'h0, stall}, 32'h0);

        do_read(32'h40, 32'h11111111, 5);
        do_read(32'h48, 32'h33333333, 0);
        do_write(32'h44, 32'hDEADBEEF);
        do_read(32'h44, 32'hDEADBEEF, 0);
`ifdef DATA_CACHE_STATS_EN
        check("miss_count", miss_count, 32'd1);
        check("hit_count", hit_count, 32'd3);
`endif
        do_write(32'hC4, 32'hCAFEF00D);
        @(negedge clock);
        check("ram_after_store", ram[8'h31], 32'hCAFEF00D);
        do_read(32'h44, 32'hDEADBEEF, 0);
        do_read(32'hC4, 32'hCAFEF00D, 5);
        do_read(32'h4C, 32'h44444444, 5);

        // Reset in the third refill cycle of a miss on 0xC0.
        @(posedge clock); #1;
        cpu_addr = 32'hC0;
        cpu_read = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        check("refill3_mem_address", mem_address, 32'hC8);
        reset_n = 1'b0;
        #1;
        check("rst_refill_mem_address", mem_address, 32'hC0);
        check("rst_refill_mem_write", {31'h0, mem_write}, 32'h0);
        cpu_read = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        do_read(32'hC0, 32'h55555555, 5);
        do_read(32'h44, 32'hDEADBEEF, 5);

        // Reset while in WRITE drops mem_write at once.
        @(posedge clock); #1;
        cpu_addr  = 32'h48;
        cpu_wdata = 32'h12345678;
        cpu_write = 1'b1;
        @(posedge clock);
        #2;
        check("write_state_mem_write", {31'h0, mem_write}, 32'h1);
        wq.push_back({32'h48, 32'h12345678});
        reset_n = 1'b0;
        #1;
        check("rst_write_mem_write", {31'h0, mem_write}, 32'h0);
        cpu_write = 1'b0;
        if (wq.size() != 0) void'(wq.pop_back());
        @(negedge clock);
        reset_n = 1'b1;
        do_read(32'h40, 32'h11111111, 5);

        repeat (2) @(posedge clock);
        check("read_queue_drained", rq.size(), 0);
        check("write_queue_drained", wq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
